// File: rtl/vic_pkg.sv
// rtl/vic_pkg.sv - shared VIC-I register indices, reset values and address helpers
package vic_pkg;

  localparam logic [3:0] VIC_R0 = 4'h0;
  localparam logic [3:0] VIC_R1 = 4'h1;
  localparam logic [3:0] VIC_R2 = 4'h2;
  localparam logic [3:0] VIC_R3 = 4'h3;
  localparam logic [3:0] VIC_R4 = 4'h4;
  localparam logic [3:0] VIC_R5 = 4'h5;
  localparam logic [3:0] VIC_R6 = 4'h6;
  localparam logic [3:0] VIC_R7 = 4'h7;
  localparam logic [3:0] VIC_R8 = 4'h8;
  localparam logic [3:0] VIC_R9 = 4'h9;
  localparam logic [3:0] VIC_RA = 4'hA;
  localparam logic [3:0] VIC_RB = 4'hB;
  localparam logic [3:0] VIC_RC = 4'hC;
  localparam logic [3:0] VIC_RD = 4'hD;
  localparam logic [3:0] VIC_RE = 4'hE;
  localparam logic [3:0] VIC_RF = 4'hF;

  localparam logic [7:0] VIC_RST [16] = '{
    8'h0C, 8'h26, 8'h96, 8'hAE, 8'h00, 8'hF0, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1B
  };

  localparam logic [15:0] VIC_COLOR_BASE_LO = 16'h9400;
  localparam logic [15:0] VIC_COLOR_BASE_HI = 16'h9600;

  // Display controls held per frame: {R5, R2[7], RF, RE[7:4], R3[0]}
  localparam int VIC_DISP_W = 22;

  // VIC sees a 14-bit space; its top bit selects between CPU $0000 and $8000 halves
  function automatic logic [15:0] vic_to_cpu_addr(input logic [13:0] va);
    return {~va[13], 2'b00, va[12:0]};
  endfunction

  function automatic logic [VIC_DISP_W-1:0] vic_pack_disp(
    input logic [7:0] r5,
    input logic       r2_b7,
    input logic [7:0] rf,
    input logic [3:0] re_hi,
    input logic       r3_b0
  );
    return {r5, r2_b7, rf, re_hi, r3_b0};
  endfunction

endpackage

// File: rtl/vic_shadow.sv
// rtl/vic_shadow.sv - frame-latched holding bank for display controls
module vic_shadow #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter bit             SHADOW  = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         frame_start_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] hold_q;
  logic [W-1:0] hold_d;

  // take a fresh copy of the live controls only at the top of the frame
  always_comb begin
    hold_d = hold_q;
    if (frame_start_i) hold_d = d_i;
  end

  // reset wins over a coincident frame_start
  always_ff @(posedge clk_i) begin
    if (!rst_ni) hold_q <= RST_VAL;
    else         hold_q <= hold_d;
  end

  assign q_o = SHADOW ? hold_q : d_i;

endmodule

// File: rtl/vic_regs.sv
// rtl/vic_regs.sv - VIC-I register file with frame-shadowed display outputs
module vic_regs
  import vic_pkg::*;
#(
  parameter bit SHADOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_en,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  output logic        vic_cs,
  input  logic        frame_start,
  input  logic [8:0]  raster,
  input  logic [7:0]  paddle_x,
  input  logic [7:0]  paddle_y,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic [3:0]  aux_color,
  output logic        inverted,
  output logic        chars8x16,
  output logic [7:0]  snd_freq0,
  output logic [7:0]  snd_freq1,
  output logic [7:0]  snd_freq2,
  output logic [7:0]  snd_freq3,
  output logic [3:0]  volume
);

  localparam logic [VIC_DISP_W-1:0] DISP_RST =
    vic_pack_disp(VIC_RST[5], VIC_RST[2][7], VIC_RST[15], VIC_RST[14][7:4], VIC_RST[3][0]);

  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic [7:0] dout_q;
  logic [7:0] dout_d;
  logic [3:0] idx;
  logic       wr_en;
  logic       rd_en;
  logic       unused_addr_bits;

  logic [VIC_DISP_W-1:0] disp_live;
  logic [VIC_DISP_W-1:0] disp;

  // $9000-$900F mirrored across the whole $90xx page; address bits 7:4 are don't-care
  assign vic_cs           = (cpu_addr[15:8] == 8'h90);
  assign idx              = cpu_addr[3:0];
  assign wr_en            = cpu_en & cpu_we & vic_cs;
  assign rd_en            = cpu_en & ~cpu_we & vic_cs;
  assign unused_addr_bits = ^cpu_addr[7:4];

  // apply CPU writes, leaving the raster/light-pen/paddle slots untouched
  always_comb begin
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];
    if (wr_en) begin
      case (idx)
        VIC_R3:                              regs_d[VIC_R3] = {regs_q[VIC_R3][7], cpu_din[6:0]};
        VIC_R4, VIC_R6, VIC_R7, VIC_R8, VIC_R9: ;
        default:                             regs_d[idx] = cpu_din;
      endcase
    end
  end

  // read mux: live inputs substitute for the read-only registers
  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (idx)
        VIC_R3:         dout_d = {raster[0], regs_q[VIC_R3][6:0]};
        VIC_R4:         dout_d = raster[8:1];
        VIC_R6, VIC_R7: dout_d = 8'h00;
        VIC_R8:         dout_d = paddle_x;
        VIC_R9:         dout_d = paddle_y;
        default:        dout_d = regs_q[idx];
      endcase
    end
  end

  // register bank and read-data latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= VIC_RST[i];
      dout_q <= 8'h00;
    end else begin
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
      dout_q <= dout_d;
    end
  end

  assign cpu_dout  = dout_q;

  assign disp_live = vic_pack_disp(regs_q[VIC_R5], regs_q[VIC_R2][7], regs_q[VIC_RF],
                                   regs_q[VIC_RE][7:4], regs_q[VIC_R3][0]);

  vic_shadow #(
    .W       (VIC_DISP_W),
    .RST_VAL (DISP_RST),
    .SHADOW  (SHADOW)
  ) u_shadow (
    .clk_i         (clk),
    .rst_ni        (reset),
    .frame_start_i (frame_start),
    .d_i           (disp_live),
    .q_o           (disp)
  );

  // unpack {R5, R2[7], RF, RE[7:4], R3[0]}
  assign screen_addr    = vic_to_cpu_addr({disp[21:18], disp[13], 9'b0});
  assign char_rom_addr  = vic_to_cpu_addr({disp[17:14], 10'b0});
  assign color_ram_addr = disp[13] ? VIC_COLOR_BASE_HI : VIC_COLOR_BASE_LO;
  assign border_color   = disp[7:5];
  assign inverted       = disp[8];
  assign back_color     = disp[12:9];
  assign aux_color      = disp[4:1];
  assign chars8x16      = disp[0];

  // audio follows the registers directly
  assign snd_freq0 = regs_q[VIC_RA];
  assign snd_freq1 = regs_q[VIC_RB];
  assign snd_freq2 = regs_q[VIC_RC];
  assign snd_freq3 = regs_q[VIC_RD];
  assign volume    = regs_q[VIC_RE][3:0];

endmodule
